interrupt_ctrl: RTL

//  Interrupt scheduler for the 8051 core; consumes IE (and IP) register contents and the five source flags.

---
 rtl/interrupt_ctrl_pkg.sv | 60 ++++++
 rtl/interrupt_ctrl_if.sv | 23 ++
 rtl/interrupt_ctrl_edge_detect.sv | 29 ++
 rtl/interrupt_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the 8051 interrupt scheduler: FSM states, source ids,
// IE/IP bit positions and vector addresses.
package interrupt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Source ids double as the poll order: lower id wins within a level.
    typedef enum logic [2:0] {
        SRC_EX0 = 3'd0,
        SRC_ET0 = 3'd1,
        SRC_EX1 = 3'd2,
        SRC_ET1 = 3'd3,
        SRC_SER = 3'd4
    } src_t;

    localparam int NUM_SRC = 5;

    localparam int IE_EA  = 7;
    localparam int IE_ES0 = 4;
    localparam int IE_ET1 = 3;
    localparam int IE_EX1 = 2;
    localparam int IE_ET0 = 1;
    localparam int IE_EX0 = 0;

    localparam int IP_PS  = 4;
    localparam int IP_PX0 = 0;

    localparam logic [15:0] VEC_EX0 = 16'h0003;
    localparam logic [15:0] VEC_ET0 = 16'h000B;
    localparam logic [15:0] VEC_EX1 = 16'h0013;
    localparam logic [15:0] VEC_ET1 = 16'h001B;
    localparam logic [15:0] VEC_SER = 16'h0023;

    function automatic logic [15:0] src_vector(input src_t s);
        logic [15:0] v;
        case (s)
            SRC_EX0: v = VEC_EX0;
            SRC_ET0: v = VEC_ET0;
            SRC_EX1: v = VEC_EX1;
            SRC_ET1: v = VEC_ET1;
            SRC_SER: v = VEC_SER;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    function automatic src_t first_src(input logic [NUM_SRC-1:0] m);
        src_t r;
        r = SRC_EX0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (m[i]) r = src_t'(3'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CPU-sequencer handshake of the interrupt scheduler: request/vector out, ack/reti in.
interface interrupt_ctrl_if #(
    parameter int VEC_W = 16
) ();
    logic             o_irq;
    logic [VEC_W-1:0] o_vector;
    logic             i_ack;
    logic             i_reti;

    modport master (
        output i_ack,
        output i_reti,
        input  o_irq,
        input  o_vector
    );

    modport slave (
        input  i_ack,
        input  i_reti,
        output o_irq,
        output o_vector
    );
endinterface

// File: rtl/interrupt_ctrl_edge_detect.sv
// INT0/INT1 request flag: falling-edge latch with ack-clear, or transparent low-level follow.
module int_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_it,
    input  logic i_pin_n,
    input  logic i_clr,
    output logic o_flag
);
    logic r_hist;
    logic r_flag;
    logic w_fall;

    assign w_fall = r_hist & ~i_pin_n;

    // A fresh edge outranks a simultaneous ack-clear so no request is lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 1'b1;
            r_flag <= 1'b0;
        end else begin
            r_hist <= i_pin_n;
            if (i_it) r_flag <= w_fall | (r_flag & ~i_clr);
            else      r_flag <= ~i_pin_n;
        end
    end

    assign o_flag = r_flag;
endmodule

// File: rtl/interrupt_ctrl.sv
// 8051 interrupt scheduler: source poll/priority encoder, request FSM and in-service tracking.
// Two-level priority from IP is built only when INTC_PRIO_EN is defined.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int VEC_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_ie,
    input  logic [7:0]         i_ip,
    input  logic               i_it0,
    input  logic               i_it1,
    input  logic               i_int0_n,
    input  logic               i_int1_n,
    input  logic               i_tf0,
    input  logic               i_tf1,
    input  logic               i_ri,
    input  logic               i_ti,
    interrupt_ctrl_if.slave    io_cpu,
    output logic               o_ie0,
    output logic               o_ie1,
    output logic               o_tf0_clr,
    output logic               o_tf1_clr,
    output logic [1:0]         o_in_service
);
    state_t               r_state;
    state_t               w_next;
    src_t                 r_src;
    logic                 r_lvl;
    logic [VEC_W-1:0]     r_vector;
    logic [1:0]           r_inSvc;
    logic [1:0]           w_inSvcNext;

    logic                 w_ie0;
    logic                 w_ie1;
    logic                 w_take;
    logic                 w_clr0;
    logic                 w_clr1;
    logic [NUM_SRC-1:0]   w_flags;
    logic [NUM_SRC-1:0]   w_cand;
    logic [NUM_SRC-1:0]   w_hiMask;
    logic [NUM_SRC-1:0]   w_candHi;
    logic [NUM_SRC-1:0]   w_candLo;
    logic                 w_found;
    logic                 w_lvl;
    src_t                 w_src;
    logic                 w_elig;
    logic                 w_irq;
    logic                 w_tf0Clr;
    logic                 w_tf1Clr;
    logic                 w_unused;

    assign w_take = (r_state == ST_REQ) && io_cpu.i_ack;
    assign w_clr0 = w_take && (r_src == SRC_EX0);
    assign w_clr1 = w_take && (r_src == SRC_EX1);

    int_edge_detect u_ext0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_it    (i_it0),
        .i_pin_n (i_int0_n),
        .i_clr   (w_clr0),
        .o_flag  (w_ie0)
    );

    int_edge_detect u_ext1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_it    (i_it1),
        .i_pin_n (i_int1_n),
        .i_clr   (w_clr1),
        .o_flag  (w_ie1)
    );

    assign w_flags = {i_ri | i_ti, i_tf1, w_ie1, i_tf0, w_ie0};
    assign w_cand  = w_flags & i_ie[IE_ES0:IE_EX0] & {NUM_SRC{i_ie[IE_EA]}};

`ifdef INTC_PRIO_EN
    assign w_hiMask = i_ip[IP_PS:IP_PX0];
`else
    assign w_hiMask = '0;
`endif
    assign w_unused = ^{i_ie[6:5], i_ip};

    assign w_candHi = w_cand & w_hiMask;
    assign w_candLo = w_cand & ~w_hiMask;

    always_comb begin
        w_found = 1'b0;
        w_lvl   = 1'b0;
        w_src   = SRC_EX0;
        if (|w_candHi) begin
            w_found = 1'b1;
            w_lvl   = 1'b1;
            w_src   = first_src(w_candHi);
        end else if (|w_candLo) begin
            w_found = 1'b1;
            w_src   = first_src(w_candLo);
        end
    end

    // A request must outrank whatever ISR level is currently running.
    assign w_elig = w_found && (w_lvl ? ~r_inSvc[1] : ~(|r_inSvc));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_elig) w_next = ST_REQ;
            ST_REQ: begin
                if (io_cpu.i_ack)  w_next = ST_ACK;
                else if (!w_elig)  w_next = ST_IDLE;
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_irq    = 1'b0;
        w_tf0Clr = 1'b0;
        w_tf1Clr = 1'b0;
        case (r_state)
            ST_REQ: w_irq = 1'b1;
            ST_ACK: begin
                w_tf0Clr = (r_src == SRC_ET0);
                w_tf1Clr = (r_src == SRC_ET1);
            end
            default: ;
        endcase
    end

    // The presented source is frozen once acked so ST_ACK pulses the right clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src    <= SRC_EX0;
            r_lvl    <= 1'b0;
            r_vector <= '0;
        end else if (w_elig && (r_state == ST_IDLE || (r_state == ST_REQ && !io_cpu.i_ack))) begin
            r_src    <= w_src;
            r_lvl    <= w_lvl;
            r_vector <= VEC_W'(src_vector(w_src));
        end
    end

    always_comb begin
        w_inSvcNext = r_inSvc;
        if (io_cpu.i_reti) begin
            if (w_inSvcNext[1]) w_inSvcNext[1] = 1'b0;
            else                w_inSvcNext[0] = 1'b0;
        end
        if (w_take) w_inSvcNext[r_lvl] = 1'b1;
`ifndef INTC_PRIO_EN
        w_inSvcNext[1] = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_inSvc <= 2'b00;
        else       r_inSvc <= w_inSvcNext;
    end

    assign io_cpu.o_irq    = w_irq;
    assign io_cpu.o_vector = r_vector;
    assign o_ie0           = w_ie0;
    assign o_ie1           = w_ie1;
    assign o_tf0_clr       = w_tf0Clr;
    assign o_tf1_clr       = w_tf1Clr;
    assign o_in_service    = r_inSvc;
endmodule
